// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the CPU data-bus responder (RAM + perf registers).
// Optional feature macro: MISALIGN_CHECK_EN.
package bus_mem_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10
  } ls_size_e;

  localparam logic [1:0] PERF_CTRL   = 2'd0;
  localparam logic [1:0] PERF_CYCLES = 2'd1;
  localparam logic [1:0] PERF_STORES = 2'd2;
  localparam logic [1:0] PERF_STATUS = 2'd3;

  localparam int unsigned CTRL_RUN_BIT        = 0;
  localparam int unsigned CTRL_CLEAR_BIT      = 1;
  localparam int unsigned STATUS_MISALIGN_BIT = 0;

  // Encoding 2'b11 behaves as a word access.
  function automatic ls_size_e decode_size(input logic [1:0] ls);
    case (ls)
      2'b00:   return LS_BYTE;
      2'b01:   return LS_HALF;
      default: return LS_WORD;
    endcase
  endfunction

endpackage

// File: rtl/bus_mem_perf_regs.sv
// Performance register window: CTRL (run/clear), CYCLES, STORES and the sticky misalign flag.
// The misalign flag can only be set when the top is built with MISALIGN_CHECK_EN.
module bus_mem_perf_regs
  import bus_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  ctrl_wdata_i,
  input  logic        ram_store_i,
  input  logic        misalign_set_i,
  output logic [31:0] rd_data_c_o,
  output logic        misalign_err_o
);

  logic        run_q, run_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] stores_q, stores_d;
  logic        err_q, err_d;
  logic        ctrl_wr;
  logic        clear;

  assign ctrl_wr = wr_en_i && (offset_i == PERF_CTRL);
  assign clear   = ctrl_wr && ctrl_wdata_i[CTRL_CLEAR_BIT];

  // Clear takes priority over increments; a new run bit applies from the following edge.
  always_comb begin
    run_d    = run_q;
    cycles_d = cycles_q;
    stores_d = stores_q;
    err_d    = err_q;
    if (clear) begin
      cycles_d = 32'd0;
      stores_d = 32'd0;
      err_d    = 1'b0;
    end else begin
      if (run_q)          cycles_d = cycles_q + 32'd1;
      if (ram_store_i)    stores_d = stores_q + 32'd1;
      if (misalign_set_i) err_d    = 1'b1;
    end
    if (ctrl_wr) run_d = ctrl_wdata_i[CTRL_RUN_BIT];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q    <= 1'b0;
      cycles_q <= 32'd0;
      stores_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      run_q    <= run_d;
      cycles_q <= cycles_d;
      stores_q <= stores_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    rd_data_c_o = 32'd0;
    case (offset_i)
      PERF_CTRL:   rd_data_c_o[CTRL_RUN_BIT] = run_q;
      PERF_CYCLES: rd_data_c_o = cycles_q;
      PERF_STORES: rd_data_c_o = stores_q;
      default:     rd_data_c_o[STATUS_MISALIGN_BIT] = err_q;
    endcase
  end

  assign misalign_err_o = err_q;

endmodule

// File: rtl/bus_data_mem_responder.sv
// CPU data-bus responder: byte-lane data RAM with sign/zero-extended loads plus perf registers.
// Define MISALIGN_CHECK_EN to suppress/flag misaligned half/word accesses.
module bus_data_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
  parameter logic [31:0] PERF_BASE = 32'h1000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  input  logic [1:0]  LSControl,
  input  logic        SignControl,
  output logic        misalign_err
);

  localparam int unsigned IDX_W   = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_END = RAM_BASE + 32'(RAM_WORDS * 4);

  ls_size_e          size;
  logic              ram_hit, perf_hit, misaligned;
  logic              ram_we, perf_we;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        lane_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       mem [RAM_WORDS];
  logic [31:0]       ram_word, load_data, perf_rdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign size     = decode_size(LSControl);
  assign ram_hit  = (busAddr >= RAM_BASE) && (busAddr < RAM_END);
  assign perf_hit = (busAddr[31:4] == PERF_BASE[31:4]);
  assign idx      = busAddr[IDX_W+1:2];

`ifdef MISALIGN_CHECK_EN
  assign misaligned = ((size == LS_HALF) && busAddr[0]) ||
                      ((size == LS_WORD) && (busAddr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign ram_we  = busWe && ram_hit && !misaligned;
  assign perf_we = busWe && perf_hit && (size == LS_WORD) && !misaligned;

  // Lane enables and store data replicated across the selected lanes.
  always_comb begin
    lane_en   = 4'b0000;
    wdata_rep = busWData;
    case (size)
      LS_BYTE: begin
        lane_en[busAddr[1:0]] = 1'b1;
        wdata_rep = {4{busWData[7:0]}};
      end
      LS_HALF: begin
        lane_en   = busAddr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{busWData[15:0]}};
      end
      default: lane_en = 4'b1111;
    endcase
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  assign ram_word = mem[idx];
  assign byte_sel = ram_word[{busAddr[1:0], 3'b000} +: 8];
  assign half_sel = busAddr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    case (size)
      LS_BYTE: load_data = {{24{SignControl & byte_sel[7]}}, byte_sel};
      LS_HALF: load_data = {{16{SignControl & half_sel[15]}}, half_sel};
      default: load_data = ram_word;
    endcase
  end

  bus_mem_perf_regs u_perf (
    .clk            (clk),
    .reset          (reset),
    .wr_en_i        (perf_we),
    .offset_i       (busAddr[3:2]),
    .ctrl_wdata_i   (busWData[1:0]),
    .ram_store_i    (ram_we),
    .misalign_set_i (misaligned && (ram_hit || perf_hit)),
    .rd_data_c_o    (perf_rdata),
    .misalign_err_o (misalign_err)
  );

  always_comb begin
    busRData = 32'd0;
    if (!reset && !misaligned) begin
      if (ram_hit)       busRData = load_data;
      else if (perf_hit) busRData = perf_rdata;
    end
  end

endmodule
